// File: rtl/switch_debounce_edge.sv
// switch_debounce_edge: per-channel synchroniser, bounce filter and
// registered rise/fall pulse generator for push-button inputs.
module switch_debounce_edge #(
  parameter int NUM_SWITCHES   = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Switch,
  output logic [NUM_SWITCHES-1:0] o_Rise,
  output logic [NUM_SWITCHES-1:0] o_Fall
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [NUM_SWITCHES-1:0] r_Sync1;
  logic [NUM_SWITCHES-1:0] r_Sync2;
  logic [NUM_SWITCHES-1:0] r_Level;
  logic [NUM_SWITCHES-1:0] r_Rise;
  logic [NUM_SWITCHES-1:0] r_Fall;
  logic [CW-1:0]           r_Count [NUM_SWITCHES];

  logic [NUM_SWITCHES-1:0] w_Differ;
  logic [NUM_SWITCHES-1:0] w_Accept;

  // A channel flips once it has disagreed for the final counted cycle.
  always_comb begin
    w_Differ = r_Sync2 ^ r_Level;
    w_Accept = '0;
    for (int n = 0; n < NUM_SWITCHES; n++) begin
      w_Accept[n] = w_Differ[n] && (r_Count[n] == LAST);
    end
  end

  // Two-flop synchroniser bringing the raw pins into i_Clk.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Sync1 <= '0;
      r_Sync2 <= '0;
    end else begin
      r_Sync1 <= i_Switch;
      r_Sync2 <= r_Sync1;
    end
  end

  // Disagreement counters: restart on agreement or acceptance.
  always_ff @(posedge i_Clk) begin
    for (int n = 0; n < NUM_SWITCHES; n++) begin
      if (i_Reset) begin
        r_Count[n] <= '0;
      end else if (!w_Differ[n] || w_Accept[n]) begin
        r_Count[n] <= '0;
      end else begin
        r_Count[n] <= r_Count[n] + ONE;
      end
    end
  end

  // Stable level and pulses, registered together so they align.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Level <= '0;
      r_Rise  <= '0;
      r_Fall  <= '0;
    end else begin
      r_Level <= r_Level ^ w_Accept;
      r_Rise  <= w_Accept & r_Sync2;
      r_Fall  <= w_Accept & ~r_Sync2;
    end
  end

  assign o_Switch = r_Level;
  assign o_Rise   = r_Rise;
  assign o_Fall   = r_Fall;

endmodule

// File: tb/tb_switch_debounce_edge.sv
// tb_switch_debounce_edge: directed plus random stimulus, window-based
// reference model, queue scoreboard with an independent monitor.
module tb_switch_debounce_edge;

  localparam int LIM  = 4;
  localparam int NS   = 2;
  localparam int MAXC = 4096;

  typedef struct packed {
    logic [NS-1:0] lvl;
    logic [NS-1:0] rise;
    logic [NS-1:0] fall;
  } exp_t;

  logic          i_Clk = 1'b0;
  logic          i_Reset;
  logic [NS-1:0] i_Switch;
  logic [NS-1:0] o_Switch;
  logic [NS-1:0] o_Rise;
  logic [NS-1:0] o_Fall;

  switch_debounce_edge #(
    .NUM_SWITCHES  (NS),
    .DEBOUNCE_LIMIT(LIM)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Switch(i_Switch),
    .o_Switch(o_Switch),
    .o_Rise  (o_Rise),
    .o_Fall  (o_Fall)
  );

  always #5 i_Clk = ~i_Clk;

  exp_t          q[$];
  int            tests = 0;
  int            fails = 0;
  int            exp_rises = 0;
  int            obs_rises = 0;
  int            t = 0;
  bit            h_rst [MAXC];
  logic [NS-1:0] h_s1  [MAXC];
  logic [NS-1:0] h_s2  [MAXC];
  logic [NS-1:0] h_f   [MAXC];
  logic [NS-1:0] m_lvl = '0;

  // Model: the filter sees the input two edges late (reset empties the
  // pipe); a channel flips when the last LIM filter samples, none of them
  // on a reset edge, all disagree with the current level.
  task automatic step(input bit rst, input logic [NS-1:0] sw);
    exp_t          e;
    logic [NS-1:0] chg;
    bit            ok;
    i_Reset  = rst;
    i_Switch = sw;
    @(posedge i_Clk);
    h_rst[t] = rst;
    h_s1[t]  = rst ? '0 : sw;
    h_s2[t]  = (rst || t == 0) ? '0 : h_s1[t-1];
    h_f[t]   = (t == 0) ? '0 : h_s2[t-1];
    chg = '0;
    if (rst) begin
      m_lvl = '0;
    end else if (t >= LIM) begin
      for (int n = 0; n < NS; n++) begin
        ok = 1'b1;
        for (int j = t - LIM + 1; j <= t; j++) begin
          if (h_rst[j] || h_f[j][n] == m_lvl[n]) ok = 1'b0;
        end
        chg[n] = ok;
      end
    end
    e.rise = chg & ~m_lvl;
    e.fall = chg & m_lvl;
    m_lvl  = m_lvl ^ chg;
    e.lvl  = m_lvl;
    q.push_back(e);
    exp_rises += $countones(e.rise);
    t++;
    @(negedge i_Clk);
  endtask

  task automatic hold(input logic [NS-1:0] sw, input int n);
    for (int k = 0; k < n; k++) step(1'b0, sw);
  endtask

  // Monitor: every edge presents one output word; compare with the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_Clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        tests++;
        if ({o_Switch, o_Rise, o_Fall} !== {e.lvl, e.rise, e.fall}) begin
          fails++;
          $display("FAIL outputs cyc=%0d got sw=%b r=%b f=%b want sw=%b r=%b f=%b",
                   t, o_Switch, o_Rise, o_Fall, e.lvl, e.rise, e.fall);
        end
        tests++;
        if ((o_Rise & o_Fall) != '0) begin
          fails++;
          $display("FAIL both_pulses got r=%b f=%b want disjoint",
                   o_Rise, o_Fall);
        end
        obs_rises += $countones(o_Rise);
      end
    end
  end

  // Stimulus
  initial begin
    int            run [NS];
    logic [NS-1:0] sw;
    logic [NS-1:0] bounce [10];
    bounce = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00,
               2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    // reset with inputs high, then release
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    hold(2'b11, 10);
    // clean press on ch0 from all-low
    hold(2'b00, 10);
    hold(2'b01, 10);
    // bounce on ch0
    hold(2'b00, 10);
    for (int k = 0; k < 10; k++) step(1'b0, bounce[k]);
    hold(2'b01, 4);
    // glitch on ch1 while ch0 stays high
    hold(2'b11, 3);
    hold(2'b01, 8);
    // release ch0
    hold(2'b00, 10);
    // reset mid-count
    hold(2'b01, 4);
    step(1'b1, 2'b01);
    hold(2'b00, 10);
    // simultaneous change on both channels
    hold(2'b11, 10);
    hold(2'b00, 10);
    // random runs of 1..7 cycles with rare resets
    sw = 2'b00;
    for (int n = 0; n < NS; n++) run[n] = $urandom_range(1, 7);
    for (int c = 0; c < 2000; c++) begin
      for (int n = 0; n < NS; n++) begin
        run[n]--;
        if (run[n] == 0) begin
          sw[n]  = ~sw[n];
          run[n] = $urandom_range(1, 7);
        end
      end
      step($urandom_range(0, 99) == 0, sw);
    end
    repeat (3) @(posedge i_Clk);
    #2;
    tests++;
    if (obs_rises != exp_rises) begin
      fails++;
      $display("FAIL rise_count got %0d want %0d", obs_rises, exp_rises);
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
